aes_input_packer: RTL and testbench

AES_INPUT_PACKER -- requirements
Module: aes_input_packer

---
 rtl/aes_input_packer.sv | 111 +++++++++++
 tb/tb_aes_input_packer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_input_packer.sv
// Byte-stream front end for an AES-128 core. MSB-first plaintext and key bytes are packed
// into 128-bit words, and a plaintext/key pair is presented with a valid/ready handshake.
module aes_input_packer #(
    parameter int N = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_is_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] plain_text,
    output logic [N-1:0] key,
    output logic         err
);
    localparam logic [3:0] LAST_BYTE = 4'd15;

    logic [N-1:0] key_shadow;
    logic [3:0]   kcnt;
    logic [3:0]   pcnt;
    logic         pt_full;
    logic         key_valid;

    logic         in_fire;
    logic         key_fire;
    logic         pt_fire;
    logic         key_done;
    logic         pt_store;
    logic         pt_done;
    logic         pt_overrun;
    logic         handshake;
    logic         pt_full_next;
    logic         key_valid_next;
    logic [N-1:0] shadow_next;

    // Byte slot 0 lands in the top byte, slot 15 in bits [7:0].
    function automatic logic [N-1:0] put_byte(input logic [N-1:0] word,
                                              input logic [3:0]   slot,
                                              input logic [7:0]   data);
        logic [N-1:0] result;
        result = word;
        result[{~slot, 3'b000} +: 8] = data;
        return result;
    endfunction

    // A pending pair stalls both byte types, so nothing can disturb the held outputs.
    assign in_ready  = !out_valid;
    assign in_fire   = in_valid && in_ready;
    assign key_fire  = in_fire && in_is_key;
    assign pt_fire   = in_fire && !in_is_key;
    assign handshake = out_valid && out_ready;

    assign key_done   = key_fire && (kcnt == LAST_BYTE);
    assign pt_store   = pt_fire && !pt_full;
    assign pt_done    = pt_store && (pcnt == LAST_BYTE);
    assign pt_overrun = pt_fire && pt_full;

    assign shadow_next    = put_byte(key_shadow, kcnt, in_data);
    assign pt_full_next   = pt_full || pt_done;
    assign key_valid_next = key_valid || key_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shadow is a plain register, so it is cleared with everything else;
            // partial key bytes must never survive a reset.
            key_shadow <= '0;
            key        <= '0;
            plain_text <= '0;
            kcnt       <= '0;
            pcnt       <= '0;
            pt_full    <= 1'b0;
            key_valid  <= 1'b0;
            out_valid  <= 1'b0;
            err        <= 1'b0;
        end else if (handshake) begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            out_valid <= 1'b0;
            pt_full   <= 1'b0;
            pcnt      <= '0;
        end else begin
            if (key_fire) begin
                key_shadow <= shadow_next;
                kcnt       <= kcnt + 4'd1;
                if (key_done) begin
                    key       <= shadow_next;
                    key_valid <= 1'b1;
                end
            end

            if (pt_store) begin
                plain_text <= put_byte(plain_text, pcnt, in_data);
                pcnt       <= pcnt + 4'd1;
                if (pt_done) begin
                    pt_full <= 1'b1;
                end
            end

            // A full block with no key yet cannot take more plaintext: drop it and flag.
            if (pt_overrun) begin
                err <= 1'b1;
            end

            if (!out_valid && pt_full_next && key_valid_next) begin
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes_input_packer.sv
// Self-checking bench for aes_input_packer: directed scenarios with literal expectations
// plus a randomized phase, all compared every cycle against a byte-level model.
module tb_aes_input_packer;
    logic         clk        = 1'b0;
    logic         rst_n      = 1'b0;
    logic         in_valid   = 1'b0;
    logic         in_is_key  = 1'b0;
    logic         out_ready  = 1'b0;
    logic [7:0]   in_data    = 8'h00;
    logic         in_ready;
    logic         out_valid;
    logic         err;
    logic [127:0] plain_text;
    logic [127:0] key;

    int n_compared = 0;
    int n_mismatch = 0;
    bit cmp_en     = 1'b0;
    bit rand_ready = 1'b0;

    always #5 clk = ~clk;

    aes_input_packer #(.N(128)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_is_key  (in_is_key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plain_text (plain_text),
        .key        (key),
        .err        (err)
    );

    // Reference model: byte counts and whole-word images, updated once per edge.
    logic [127:0] m_shadow;
    logic [127:0] m_key;
    logic [127:0] m_pt;
    int           m_kn;
    int           m_pn;
    bit           m_pt_full;
    bit           m_key_valid;
    bit           m_out_valid;
    bit           m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_shadow    <= '0;
            m_key       <= '0;
            m_pt        <= '0;
            m_kn        <= 0;
            m_pn        <= 0;
            m_pt_full   <= 1'b0;
            m_key_valid <= 1'b0;
            m_out_valid <= 1'b0;
            m_err       <= 1'b0;
        end else if (m_out_valid) begin
            if (out_ready) begin
                m_out_valid <= 1'b0;
                m_pt_full   <= 1'b0;
                m_pn        <= 0;
            end
        end else if (in_valid && in_is_key) begin
            m_shadow[127 - 8*m_kn -: 8] <= in_data;
            if (m_kn == 15) begin
                m_key       <= {m_shadow[127:8], in_data};
                m_key_valid <= 1'b1;
                m_kn        <= 0;
                if (m_pt_full) m_out_valid <= 1'b1;
            end else begin
                m_kn <= m_kn + 1;
            end
        end else if (in_valid && !m_pt_full) begin
            m_pt[127 - 8*m_pn -: 8] <= in_data;
            if (m_pn == 15) begin
                m_pt_full <= 1'b1;
                m_pn      <= 0;
                if (m_key_valid) m_out_valid <= 1'b1;
            end else begin
                m_pn <= m_pn + 1;
            end
        end else if (in_valid) begin
            m_err <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatch++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("in_ready",   128'(in_ready),  128'(!m_out_valid));
            check("out_valid",  128'(out_valid), 128'(m_out_valid));
            check("err",        128'(err),       128'(m_err));
            check("key",        key,             m_key);
            check("plain_text", plain_text,      m_pt);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge; returns on the negedge after the byte is accepted.
    task automatic send_byte(input bit is_key, input logic [7:0] data);
        int waited;
        bit took;
        waited    = 0;
        in_valid  = 1'b1;
        in_is_key = is_key;
        in_data   = data;
        do begin
            took = in_ready;
            @(negedge clk);
            waited++;
            if (!took && rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end while (!took && waited < 200);
        check("byte_accepted", 128'(took), 128'(1));
        in_valid  = 1'b0;
        in_is_key = 1'($urandom);
        in_data   = 8'($urandom);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        tick(2);
        #2 rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] exp_key;
        logic [127:0] exp_pt;
        logic [7:0]   b;

        // Reset state
        tick(2);
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_in_ready",  128'(in_ready),  128'(1));
        check("rst_err",       128'(err),       128'(0));
        check("rst_key",       key,             128'h0);
        check("rst_pt",        plain_text,      128'h0);
        cmp_en = 1'b1;
        #2 rst_n = 1'b1;
        tick(1);

        // Basic load with a ready consumer
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send_byte(1'b1, 8'(i));
        for (int i = 0; i < 16; i++) send_byte(1'b0, 8'(i * 17));
        check("basic_key",   key,             128'h000102030405060708090A0B0C0D0E0F);
        check("basic_pt",    plain_text,      128'h00112233445566778899AABBCCDDEEFF);
        check("basic_valid", 128'(out_valid), 128'(1));
        tick(1);
        check("basic_valid_drop", 128'(out_valid), 128'(0));

        // Key reuse under backpressure
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_byte(1'b0, 8'(i * 16 + 15));
        check("reuse_valid", 128'(out_valid), 128'(1));
        check("reuse_key",   key,             128'h000102030405060708090A0B0C0D0E0F);
        check("reuse_err",   128'(err),       128'(0));
        in_valid  = 1'b1;
        in_is_key = 1'($urandom);
        in_data   = 8'($urandom);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("stall_in_ready", 128'(in_ready), 128'(0));
            check("stall_pt", plain_text, 128'h0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFFF);
        end
        out_ready = 1'b1;
        tick(1);
        in_valid = 1'b0;
        check("release_valid", 128'(out_valid), 128'(0));
        check("release_ready", 128'(in_ready),  128'(1));

        // Plaintext before any key, with overrun bytes
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_byte(1'b0, 8'(8'hA0 + i));
        check("ovr_err_before", 128'(err), 128'(0));
        for (int i = 0; i < 3; i++) send_byte(1'b0, 8'($urandom));
        check("ovr_err_after", 128'(err), 128'(1));
        for (int i = 0; i < 16; i++) send_byte(1'b1, 8'(8'h40 + i));
        check("ovr_valid", 128'(out_valid), 128'(1));
        check("ovr_pt",    plain_text,      128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
        check("ovr_key",   key,             128'h404142434445464748494A4B4C4D4E4F);
        out_ready = 1'b1;
        tick(1);
        check("ovr_valid_drop", 128'(out_valid), 128'(0));

        // Interleaved key reload
        for (int i = 0; i < 8; i++) begin
            send_byte(1'b1, 8'(8'hC0 + i));
            send_byte(1'b0, 8'(i));
        end
        check("reload_half_key", key, 128'h404142434445464748494A4B4C4D4E4F);
        for (int i = 8; i < 15; i++) send_byte(1'b1, 8'(8'hC0 + i));
        check("reload_15_key", key, 128'h404142434445464748494A4B4C4D4E4F);
        send_byte(1'b1, 8'hCF);
        check("reload_new_key", key,             128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF);
        check("reload_no_pair", 128'(out_valid), 128'(0));
        for (int i = 8; i < 16; i++) send_byte(1'b0, 8'(i));
        check("reload_valid", 128'(out_valid), 128'(1));
        check("reload_pt",    plain_text,      128'h000102030405060708090A0B0C0D0E0F);
        tick(1);

        // Reset in the middle of a plaintext load
        for (int i = 0; i < 7; i++) send_byte(1'b0, 8'(8'h70 + i));
        #3 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        check("midrst_in_ready",  128'(in_ready),  128'(1));
        check("midrst_err",       128'(err),       128'(0));
        check("midrst_key",       key,             128'h0);
        check("midrst_pt",        plain_text,      128'h0);
        tick(1);
        #2 rst_n = 1'b1;
        tick(1);
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            exp_key[127 - 8*i -: 8] = b;
            send_byte(1'b1, b);
        end
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            exp_pt[127 - 8*i -: 8] = b;
            send_byte(1'b0, b);
        end
        check("fresh_valid", 128'(out_valid), 128'(1));
        check("fresh_key",   key,             exp_key);
        check("fresh_pt",    plain_text,      exp_pt);
        tick(1);

        // Randomized traffic from a clean state
        do_reset();
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) tick(1);
            send_byte($urandom_range(0, 2) == 0, 8'($urandom));
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
